// File: rtl/mips_isa_pkg.sv
// MIPS opcode/funct map and symbolic request kinds shared by the loader and the control decoder.
package mips_isa_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;

  typedef enum logic [3:0] {
    K_ADD  = 4'd0,
    K_SUB  = 4'd1,
    K_AND  = 4'd2,
    K_OR   = 4'd3,
    K_NOR  = 4'd4,
    K_ADDI = 4'd5,
    K_ORI  = 4'd6,
    K_ANDI = 4'd7,
    K_LUI  = 4'd8,
    K_LW   = 4'd9,
    K_SW   = 4'd10,
    K_BEQ  = 4'd11,
    K_BNE  = 4'd12,
    K_J    = 4'd13,
    K_JAL  = 4'd14,
    K_LI   = 4'd15
  } req_kind_e;

  // LI only needs the LUI half when the upper 16 bits are non-zero.
  function automatic logic li_needs_two(input logic [31:0] imm);
    return imm[31:16] != 16'h0000;
  endfunction

endpackage

// File: rtl/instr_word_encoder.sv
// Combinational encoder: symbolic request -> 32-bit MIPS word.
// second_i selects the trailing ORI rt,rt,imm[15:0] word of a two-word LI.
module instr_word_encoder
  import mips_isa_pkg::*;
(
  input  req_kind_e   kind_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [31:0] imm_i,
  input  logic        second_i,
  output logic [31:0] word_o
);

  always_comb begin
    word_o = 32'h0000_0000;
    if (second_i) begin
      word_o = {OP_ORI, rt_i, rt_i, imm_i[15:0]};
    end else begin
      case (kind_i)
        K_ADD:  word_o = {OP_RTYPE, rs_i, rt_i, rd_i, 5'b0, FN_ADD};
        K_SUB:  word_o = {OP_RTYPE, rs_i, rt_i, rd_i, 5'b0, FN_SUB};
        K_AND:  word_o = {OP_RTYPE, rs_i, rt_i, rd_i, 5'b0, FN_AND};
        K_OR:   word_o = {OP_RTYPE, rs_i, rt_i, rd_i, 5'b0, FN_OR};
        K_NOR:  word_o = {OP_RTYPE, rs_i, rt_i, rd_i, 5'b0, FN_NOR};
        K_ADDI: word_o = {OP_ADDI, rs_i, rt_i, imm_i[15:0]};
        K_ORI:  word_o = {OP_ORI, rs_i, rt_i, imm_i[15:0]};
        K_ANDI: word_o = {OP_ANDI, rs_i, rt_i, imm_i[15:0]};
        K_LUI:  word_o = {OP_LUI, 5'b0, rt_i, imm_i[15:0]};
        K_LW:   word_o = {OP_LW, rs_i, rt_i, imm_i[15:0]};
        K_SW:   word_o = {OP_SW, rs_i, rt_i, imm_i[15:0]};
        K_BEQ:  word_o = {OP_BEQ, rs_i, rt_i, imm_i[15:0]};
        K_BNE:  word_o = {OP_BNE, rs_i, rt_i, imm_i[15:0]};
        K_J:    word_o = {OP_J, imm_i[25:0]};
        K_JAL:  word_o = {OP_JAL, imm_i[25:0]};
        K_LI:   word_o = li_needs_two(imm_i) ? {OP_LUI, 5'b0, rt_i, imm_i[31:16]}
                                             : {OP_ORI, 5'b0, rt_i, imm_i[15:0]};
        default: word_o = 32'h0000_0000;
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Boot/test program loader: encodes symbolic requests and writes them one word
// per cycle into instruction memory, expanding LI into LUI+ORI when needed.
module instr_encoder_loader
  import mips_isa_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0,
  parameter int DEPTH      = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [3:0]            req_kind,
  input  logic [4:0]            req_rs,
  input  logic [4:0]            req_rt,
  input  logic [4:0]            req_rd,
  input  logic [31:0]           req_imm,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full
);

  typedef enum logic [1:0] {S_IDLE, S_EMIT2, S_FULL} state_e;

  localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] BASE_C  = ADDR_WIDTH'(BASE_ADDR);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic [31:0]           pend_q, pend_d;

  req_kind_e   kind;
  logic [31:0] words [2];
  logic        two_word, short_room, accept, emit;
  logic [31:0] emit_word;

  assign kind = req_kind_e'(req_kind);

  // Instance 0 produces the first (or only) word, instance 1 the trailing LI ORI.
  for (genvar gi = 0; gi < 2; gi++) begin : g_enc
    instr_word_encoder u_enc (
      .kind_i   (kind),
      .rs_i     (req_rs),
      .rt_i     (req_rt),
      .rd_i     (req_rd),
      .imm_i    (req_imm),
      .second_i (gi == 1),
      .word_o   (words[gi])
    );
  end

  assign two_word   = (kind == K_LI) && li_needs_two(req_imm);
  assign short_room = (DEPTH_C - count_q) < (ADDR_WIDTH+1)'(2);
  assign full       = (count_q == DEPTH_C);
  // A two-word LI is refused outright when only one slot remains, so it is never split.
  assign req_ready  = (state_q == S_IDLE) && !full && !clear && !(two_word && short_room);
  assign accept     = req_valid && req_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= BASE_C;
      mem_wdata_q <= 32'h0000_0000;
      pend_q      <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      pend_q      <= pend_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    pend_d      = pend_q;
    emit        = 1'b0;
    emit_word   = words[0];

    if (clear) begin
      state_d    = S_IDLE;
      count_d    = '0;
      mem_addr_d = BASE_C;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            emit = 1'b1;
            if (two_word) pend_d = words[1];
          end
        end
        S_EMIT2: begin
          emit      = 1'b1;
          emit_word = pend_q;
        end
        default: ;
      endcase
    end

    if (emit) begin
      mem_we_d    = 1'b1;
      mem_addr_d  = BASE_C + count_q[ADDR_WIDTH-1:0];
      mem_wdata_d = emit_word;
      count_d     = count_q + (ADDR_WIDTH+1)'(1);
      if (state_q == S_IDLE && two_word)
        state_d = S_EMIT2;
      else if (count_d == DEPTH_C)
        state_d = S_FULL;
      else
        state_d = S_IDLE;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign count     = count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench: directed scenarios plus randomized requests against a word-queue reference model.
module tb_instr_encoder_loader;

  localparam int AW    = 5;
  localparam int BASE  = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset, clear, req_valid, req_ready;
  logic [3:0]    req_kind;
  logic [4:0]    req_rs, req_rt, req_rd;
  logic [31:0]   req_imm;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   count;
  logic          full;

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .clear(clear), .req_valid(req_valid), .req_ready(req_ready),
    .req_kind(req_kind), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_imm(req_imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .count(count), .full(full)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: words still owed to memory, and words written so far.
  logic [31:0] exp_q [$];
  int          m_cnt;
  bit          exp_we;
  int          exp_addr;
  logic [31:0] exp_data;

  logic [5:0] r_funct [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27};
  logic [5:0] i_op    [8] = '{6'h08, 6'h0d, 6'h0c, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h05};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void push_words(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] rd, input logic [31:0] imm);
    int ki;
    ki = int'(k);
    if (ki <= 4)
      exp_q.push_back({6'h00, rs, rt, rd, 5'd0, r_funct[ki]});
    else if (ki <= 12)
      exp_q.push_back({i_op[ki-5], (ki == 8) ? 5'd0 : rs, rt, imm[15:0]});
    else if (ki == 13)
      exp_q.push_back({6'h02, imm[25:0]});
    else if (ki == 14)
      exp_q.push_back({6'h03, imm[25:0]});
    else if (imm[31:16] != 16'h0) begin
      exp_q.push_back({6'h0f, 5'd0, rt, imm[31:16]});
      exp_q.push_back({6'h0d, rt, rt, imm[15:0]});
    end else
      exp_q.push_back({6'h0d, 5'd0, rt, imm[15:0]});
  endfunction

  // Called at posedge+1: drives one cycle of inputs, checks ready, advances the model, checks outputs.
  task automatic step(input bit clr, input bit v, input logic [3:0] k, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] imm, output bit acc);
    bit exp_ready;
    clear = clr; req_valid = v; req_kind = k; req_rs = rs; req_rt = rt; req_rd = rd; req_imm = imm;
    #2;
    exp_ready = (exp_q.size() == 0) && (m_cnt < DEPTH) && !clr &&
                !(k == 4'd15 && imm[31:16] != 16'h0 && (DEPTH - m_cnt) < 2);
    chk("req_ready", req_ready, exp_ready);
    acc = v && exp_ready;
    if (clr) begin
      exp_q.delete();
      m_cnt  = 0;
      exp_we = 0;
    end else begin
      if (acc) begin
        push_words(k, rs, rt, rd, imm);
        $display("txn kind=%0d rs=%0d rt=%0d rd=%0d imm=%08h words=%0d", k, rs, rt, rd, imm, exp_q.size());
      end
      if (exp_q.size() > 0) begin
        exp_we   = 1;
        exp_addr = BASE + m_cnt;
        exp_data = exp_q.pop_front();
        m_cnt++;
      end else
        exp_we = 0;
    end
    @(posedge clk); #1;
    chk("mem_we", mem_we, exp_we);
    if (exp_we) begin
      chk("mem_addr", mem_addr, exp_addr);
      chk("mem_wdata", mem_wdata, exp_data);
    end
    chk("count", count, m_cnt);
    chk("full", full, m_cnt == DEPTH);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          a;
    logic [3:0]  r_k;
    logic [4:0]  r_rs, r_rt, r_rd;
    logic [31:0] r_imm;
    bit          r_v, r_clr;

    reset = 1'b1; clear = 1'b0; req_valid = 1'b0; req_kind = 4'd0;
    req_rs = '0; req_rt = '0; req_rd = '0; req_imm = '0;
    m_cnt = 0; exp_we = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, BASE);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    reset = 1'b0;

    step(0, 1, 4'd0, 5'd1, 5'd2, 5'd3, 32'h0, a);
    chk("add_word", mem_wdata, 32'h0022_1820);
    step(1, 0, 4'd0, 0, 0, 0, 0, a);

    step(0, 1, 4'd15, 5'd0, 5'd8, 5'd0, 32'h1234_5678, a);
    chk("li_hi_word", mem_wdata, 32'h3C08_1234);
    step(0, 0, 4'd0, 0, 0, 0, 0, a);
    chk("li_lo_word", mem_wdata, 32'h3508_5678);
    step(0, 1, 4'd15, 5'd0, 5'd9, 5'd0, 32'h0000_BEEF, a);
    chk("li_short_word", mem_wdata, 32'h3409_BEEF);
    step(0, 1, 4'd13, 5'd0, 5'd0, 5'd0, 32'h0040_0010, a);
    chk("j_word", mem_wdata, 32'h0840_0010);
    step(0, 0, 4'd0, 0, 0, 0, 0, a);
    step(1, 0, 4'd0, 0, 0, 0, 0, a);
    step(0, 1, 4'd14, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, a);
    chk("jal_word", mem_wdata, 32'h0FFF_FFFF);

    // Fill to DEPTH-1, then a two-word LI must be refused and a single word fills the memory.
    step(1, 0, 4'd0, 0, 0, 0, 0, a);
    for (int i = 0; i < 3; i++) step(0, 1, 4'd1, 5'(i), 5'(i + 4), 5'(i + 9), 32'h0, a);
    step(0, 1, 4'd15, 5'd0, 5'd4, 5'd0, 32'h0001_0002, a);
    step(0, 1, 4'd0, 5'd5, 5'd6, 5'd7, 32'h0, a);
    chk("full_after_add", full, 1);
    step(0, 1, 4'd0, 5'd5, 5'd6, 5'd7, 32'h0, a);
    step(1, 0, 4'd0, 0, 0, 0, 0, a);
    step(0, 1, 4'd3, 5'd1, 5'd1, 5'd1, 32'h0, a);
    chk("addr_after_clear", mem_addr, BASE);

    // Async reset while the ORI half of an LI is pending.
    step(1, 0, 4'd0, 0, 0, 0, 0, a);
    step(0, 1, 4'd15, 5'd0, 5'd3, 5'd0, 32'hABCD_0001, a);
    req_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("async_rst_we", mem_we, 0);
    chk("async_rst_count", count, 0);
    exp_q.delete();
    m_cnt = 0;
    @(posedge clk); #1;
    chk("async_rst_we_hold", mem_we, 0);
    reset = 1'b0;
    step(0, 0, 4'd0, 0, 0, 0, 0, a);

    r_v = 0; a = 0; r_k = '0; r_rs = '0; r_rt = '0; r_rd = '0; r_imm = '0;
    for (int i = 0; i < 400; i++) begin
      if (!(r_v && !a)) begin
        r_v   = ($urandom_range(0, 9) < 7);
        r_k   = 4'($urandom_range(0, 15));
        r_rs  = 5'($urandom);
        r_rt  = 5'($urandom);
        r_rd  = 5'($urandom);
        r_imm = $urandom;
        if ($urandom_range(0, 2) == 0) r_imm[31:16] = 16'h0;
      end
      r_clr = ($urandom_range(0, 19) == 0);
      step(r_clr, r_v, r_k, r_rs, r_rt, r_rd, r_imm, a);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
